// File: rtl/hive_pkg.sv
// Hive geometry, pixel format and damage-controller state encoding, shared by the
// hive drawing, collision and damage-control blocks.
package hive_pkg;

    localparam int HIVE_W     = 66;
    localparam int HIVE_H     = 39;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int HIT_W      = 13;

    localparam logic [DATA_W-1:0] CLEAR_COLOR = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ERASE = 2'd2
    } dmg_state_e;

endpackage

// File: rtl/hit_fifo.sv
// Small synchronous FIFO holding pending collision hits as packed {x,y} words.
module hit_fifo #(
    parameter int WIDTH = hive_pkg::HIT_W,
    parameter int DEPTH = hive_pkg::FIFO_DEPTH
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/hive_damage_ctrl.sv
// Hive RAM port controller: display reads always win, queued collision hits are
// expanded into 2x2 CLEAR_COLOR erase bursts that use only idle RAM cycles.
module hive_damage_ctrl #(
    parameter int                HIVE_W      = hive_pkg::HIVE_W,
    parameter int                HIVE_H      = hive_pkg::HIVE_H,
    parameter int                ADDR_W      = hive_pkg::ADDR_W,
    parameter int                DATA_W      = hive_pkg::DATA_W,
    parameter int                FIFO_DEPTH  = hive_pkg::FIFO_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = hive_pkg::CLEAR_COLOR
) (
    input  logic              clk_pix,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_dout,
    input  logic              hit_valid,
    output logic              hit_ready,
    input  logic [6:0]        hit_x,
    input  logic [5:0]        hit_y,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        ram_write,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_dout
);

    import hive_pkg::*;

    localparam logic [7:0] HIVE_W_B = 8'(HIVE_W);
    localparam logic [6:0] HIVE_H_B = 7'(HIVE_H);

    dmg_state_e        state;
    dmg_state_e        state_next;
    logic [6:0]        cur_x;
    logic [6:0]        cur_x_next;
    logic [5:0]        cur_y;
    logic [5:0]        cur_y_next;
    logic [1:0]        sub;
    logic [1:0]        sub_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [12:0]       fifo_head;
    logic              erase_wr;
    logic              erase_step;
    logic [7:0]        tgt_x;
    logic [6:0]        tgt_y;
    logic              tgt_in;
    logic [ADDR_W-1:0] tgt_addr;
    logic              disp_req_d;

    assign fifo_push = hit_valid && !fifo_full;
    assign hit_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign disp_dout = ram_dout;

    hit_fifo #(
        .WIDTH (13),
        .DEPTH (FIFO_DEPTH)
    ) u_hit_fifo (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     ({hit_x, hit_y}),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Targets are widened by one bit so x+1 and y+1 past the hive edge compare correctly.
    assign tgt_x    = {1'b0, cur_x} + {7'b0, sub[0]};
    assign tgt_y    = {1'b0, cur_y} + {6'b0, sub[1]};
    assign tgt_in   = (tgt_x < HIVE_W_B) && (tgt_y < HIVE_H_B);
    assign tgt_addr = ADDR_W'({tgt_y, 6'b0}) + ADDR_W'({tgt_y, 1'b0}) + ADDR_W'(tgt_x);

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur_x <= '0;
            cur_y <= '0;
            sub   <= '0;
        end else begin
            state <= state_next;
            cur_x <= cur_x_next;
            cur_y <= cur_y_next;
            sub   <= sub_next;
        end
    end

    // Out-of-hive targets are skipped without waiting for a free RAM slot.
    always_comb begin
        state_next = state;
        cur_x_next = cur_x;
        cur_y_next = cur_y;
        sub_next   = sub;
        fifo_pop   = 1'b0;
        erase_wr   = 1'b0;
        erase_step = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cur_x_next = fifo_head[12:6];
                    cur_y_next = fifo_head[5:0];
                    state_next = LOAD;
                end
            end
            LOAD: begin
                sub_next = 2'd0;
                if (({1'b0, cur_x} >= HIVE_W_B) || ({1'b0, cur_y} >= HIVE_H_B)) begin
                    state_next = IDLE;
                end else begin
                    state_next = ERASE;
                end
            end
            ERASE: begin
                if (tgt_in) begin
                    erase_wr   = !disp_req;
                    erase_step = !disp_req;
                end else begin
                    erase_step = 1'b1;
                end
                if (erase_step) begin
                    sub_next = sub + 2'd1;
                    if (sub == 2'd3) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr  <= '0;
            ram_write <= 2'b00;
            ram_data  <= '0;
        end else if (disp_req) begin
            ram_addr  <= disp_addr;
            ram_write <= 2'b00;
        end else if (erase_wr) begin
            ram_addr  <= tgt_addr;
            ram_data  <= CLEAR_COLOR;
            ram_write <= 2'b01;
        end else begin
            ram_write <= 2'b00;
        end
    end

    // Two-stage delay matches the registered address plus the RAM's registered read.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            disp_req_d <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            disp_req_d <= disp_req;
            disp_valid <= disp_req_d;
        end
    end

endmodule

// File: tb/tb_hive_damage_ctrl.sv
// Bench for hive_damage_ctrl: behavioural hive RAM plus queues of expected erase
// writes and display read data, popped as the DUT produces them.
module tb_hive_damage_ctrl;

    localparam logic [7:0] CLEAR = 8'h00;

    logic        clk_pix = 1'b0;
    logic        rst_n;
    logic        disp_req;
    logic [11:0] disp_addr;
    logic        disp_valid;
    logic [7:0]  disp_dout;
    logic        hit_valid;
    logic        hit_ready;
    logic [6:0]  hit_x;
    logic [5:0]  hit_y;
    logic        busy;
    logic [11:0] ram_addr;
    logic [1:0]  ram_write;
    logic [7:0]  ram_data;
    logic [7:0]  ram_dout;

    int nChecks = 0;
    int nFails  = 0;
    int wrSeen  = 0;

    logic [11:0] wrQ[$];
    logic [7:0]  rdQ[$];

    bit [7:0] mem     [4096];
    bit       wflag   [4096];
    bit       cleared [4096];

    always #5 clk_pix = ~clk_pix;

    hive_damage_ctrl dut (
        .clk_pix    (clk_pix),
        .rst_n      (rst_n),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_dout  (disp_dout),
        .hit_valid  (hit_valid),
        .hit_ready  (hit_ready),
        .hit_x      (hit_x),
        .hit_y      (hit_y),
        .busy       (busy),
        .ram_addr   (ram_addr),
        .ram_write  (ram_write),
        .ram_data   (ram_data),
        .ram_dout   (ram_dout)
    );

    function automatic logic [7:0] preload(input logic [11:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] expectedPixel(input logic [11:0] a);
        return cleared[a] ? CLEAR : preload(a);
    endfunction

    // Registered-read single-port RAM; never-written cells return the preload pattern.
    always @(posedge clk_pix) begin
        ram_dout <= wflag[ram_addr] ? mem[ram_addr] : preload(ram_addr);
        if (ram_write == 2'b01) begin
            mem[ram_addr]   <= ram_data;
            wflag[ram_addr] <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), wanted %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    function automatic void pushHit(input int hx, input int hy);
        int tx;
        int ty;
        for (int s = 0; s < 4; s++) begin
            tx = hx + (s % 2);
            ty = hy + (s / 2);
            if (tx < 66 && ty < 39) begin
                wrQ.push_back(12'(ty * 66 + tx));
                cleared[ty * 66 + tx] = 1'b1;
            end
        end
    endfunction

    task automatic applyStimulus(input logic req, input logic [11:0] addr, input logic hv,
                                 input int hx, input int hy, input logic expAccept);
        @(posedge clk_pix);
        #1;
        disp_req  = req;
        disp_addr = addr;
        hit_valid = hv;
        hit_x     = 7'(hx);
        hit_y     = 6'(hy);
        if (req) rdQ.push_back(expectedPixel(addr));
        if (hv) begin
            checkOutput("hit_ready", 32'(hit_ready), 32'(expAccept));
            if (expAccept) pushHit(hx, hy);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 12'd0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic drainIdle(input int maxCycles, input string tag);
        int n = 0;
        do begin
            idleCycle();
            n++;
        end while ((wrQ.size() != 0 || rdQ.size() != 0 || busy) && n < maxCycles);
        repeat (4) idleCycle();
        checkOutput({tag, "_writes_left"}, 32'(wrQ.size()), 32'd0);
        checkOutput({tag, "_reads_left"}, 32'(rdQ.size()), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic hitAndCount(input int hx, input int hy, input int expWrites, input string tag);
        int base;
        base = wrSeen;
        applyStimulus(1'b0, 12'd0, 1'b1, hx, hy, 1'b1);
        drainIdle(30, tag);
        checkOutput({tag, "_write_count"}, 32'(wrSeen - base), 32'(expWrites));
    endtask

    // Every RAM write and every valid display word is matched against the queues.
    always @(negedge clk_pix) begin
        if (rst_n) begin
            if (ram_write != 2'b00) begin
                wrSeen++;
                checkOutput("ram_write_code", 32'(ram_write), 32'd1);
                if (wrQ.size() == 0) begin
                    checkOutput("unexpected_write_addr", 32'(ram_addr), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("write_addr", 32'(ram_addr), 32'(wrQ.pop_front()));
                    checkOutput("write_data", 32'(ram_data), 32'(CLEAR));
                end
            end
            if (disp_valid) begin
                if (rdQ.size() == 0) begin
                    checkOutput("unexpected_disp_valid", 32'(disp_dout), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("disp_dout", 32'(disp_dout), 32'(rdQ.pop_front()));
                end
            end
        end
    end

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: time %0t reached without finishing, required earlier finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  pat;
        logic [7:0]  busyPat;
        logic [5:0]  validPat;
        int          base;
        logic        prevReq;
        logic        curReq;
        logic [11:0] readback [11];

        rst_n     = 1'b0;
        disp_req  = 1'b0;
        disp_addr = '0;
        hit_valid = 1'b0;
        hit_x     = '0;
        hit_y     = '0;
        repeat (3) @(posedge clk_pix);
        #1;
        checkOutput("reset_ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("reset_ram_write", 32'(ram_write), 32'd0);
        checkOutput("reset_ram_data", 32'(ram_data), 32'd0);
        checkOutput("reset_disp_valid", 32'(disp_valid), 32'd0);
        checkOutput("reset_hit_ready", 32'(hit_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        @(negedge clk_pix);
        rst_n = 1'b1;

        // Back-to-back display reads of addresses 0,1,2.
        validPat = '0;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) applyStimulus(1'b1, 12'(c), 1'b0, 0, 0, 1'b0);
            else       idleCycle();
            @(negedge clk_pix);
            validPat[c] = disp_valid;
        end
        checkOutput("disp_valid_pattern", 32'(validPat), 32'b011100);
        drainIdle(20, "reads");

        // Uncontended burst: pop, LOAD, then four consecutive writes.
        applyStimulus(1'b0, 12'd0, 1'b1, 10, 5, 1'b1);
        pat     = '0;
        busyPat = '0;
        for (int c = 0; c < 8; c++) begin
            idleCycle();
            @(negedge clk_pix);
            pat[c]     = ram_write[0];
            busyPat[c] = busy;
        end
        checkOutput("burst_write_timing", 32'(pat), 32'b0111_1000);
        checkOutput("burst_busy_timing", 32'(busyPat), 32'b0011_1111);
        drainIdle(20, "burst");

        // Hive edges and an out-of-range hit.
        hitAndCount(65, 38, 1, "corner");
        hitAndCount(70, 3, 0, "outside");
        hitAndCount(65, 10, 2, "right_edge");
        hitAndCount(5, 38, 2, "bottom_edge");

        // Alternating display reads: erase may only use the idle slots.
        base    = wrSeen;
        prevReq = 1'b0;
        for (int c = 0; c < 24; c++) begin
            curReq = (c % 2 == 0);
            applyStimulus(curReq, 12'(3000 + c), (c == 0), 0, 0, 1'b1);
            @(negedge clk_pix);
            if (ram_write[0]) checkOutput("write_only_when_display_idle", 32'(prevReq), 32'd0);
            prevReq = curReq;
        end
        drainIdle(20, "toggle");
        checkOutput("toggle_write_count", 32'(wrSeen - base), 32'd4);

        // Display held busy: queue fills (one entry already sits in the FSM).
        base = wrSeen;
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 12'(3100 + k), 1'b1, 30 + 2 * k, 10, (k < 5));
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 12'(3110 + k), 1'b1, 50, 20, 1'b0);
        checkOutput("held_busy", 32'(busy), 32'd1);
        checkOutput("held_no_writes", 32'(wrSeen - base), 32'd0);
        drainIdle(100, "queue");
        checkOutput("queue_write_count", 32'(wrSeen - base), 32'd20);

        // Reset after the second write of a burst.
        applyStimulus(1'b0, 12'd0, 1'b1, 20, 20, 1'b1);
        idleCycle();
        base = wrSeen;
        for (int c = 0; c < 20 && (wrSeen - base) < 2; c++) begin
            @(negedge clk_pix);
            #1;
        end
        checkOutput("rst_writes_before", 32'(wrSeen - base), 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_hit_ready", 32'(hit_ready), 32'd1);
        checkOutput("rst_ram_write", 32'(ram_write), 32'd0);
        checkOutput("rst_pending_writes", 32'(wrQ.size()), 32'd2);
        while (wrQ.size() != 0) cleared[wrQ.pop_front()] = 1'b0;
        repeat (2) @(negedge clk_pix);
        rst_n = 1'b1;
        drainIdle(10, "post_reset");
        checkOutput("rst_write_total", 32'(wrSeen - base), 32'd2);

        // Read back RAM contents through the display path.
        readback = '{12'd340, 12'd341, 12'd406, 12'd407, 12'd2573, 12'd725,
                     12'd0, 12'd67, 12'd1340, 12'd1406, 12'd342};
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, readback[i], 1'b0, 0, 0, 1'b0);
        drainIdle(10, "readback");

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
